start_code_scanner: RTL and testbench
=====================================

Name: start_code_scanner

Overview:
- Sits directly downstream of the stream splitter and consumes its video elementary-stream byte output (vid_out / vid_out_en).
- Scans for MPEG start codes (00 00 01 xx), removes the 3-byte prefix and the code byte from the data path, and reports the code value on a side channel.
- Passes all other bytes through in order through a 2-entry delay line.
- The downstream header/slice parser consumes the aligned data and code events.

Parameters:
- CNT_W, 16, width of the saturating data-byte counter reported with each start code.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- vid_in  in  8  video ES byte (from splitter vid_out)
- vid_in_en  in  1  byte valid; at most one byte per cycle; no backpressure
- flush  in  1  one-cycle pulse at end of stream; drains the delay line
- data_out  out  8  payload byte, prefix and code bytes removed
- data_out_en  out  1  data_out valid, one-cycle strobe per byte
- start_code  out  8  code value byte following 00 00 01
- start_code_valid  out  1  one-cycle strobe
- unit_bytes  out  CNT_W  data bytes emitted since previous start code; valid with start_code_valid
- busy  out  1  delay line holds at least one pending byte

Behaviour:
- Reset (rst=0, async): data_out=0, data_out_en=0, start_code=0, start_code_valid=0, unit_bytes=0, busy=0. Delay line is emptied, FSM goes to SCAN, counter=0, drain count=0.
- Delay line: s0 (newest) and s1, each with a valid bit.
- A shift occurs in a cycle when (vid_in_en and FSM=SCAN) or drain_cnt>0.
  - On a shift, s1 leaves; if valid it appears registered on data_out with data_out_en=1 the next cycle.
  - s0 moves to s1. s0 takes vid_in if vid_in_en, otherwise a bubble (invalid).
- Latency for a normally accepted byte is 2 further accepted bytes (or flush) plus 1 cycle.
- FSM states SCAN and CODE.
  - SCAN, vid_in_en, vid_in=01, s0 and s1 both valid and 00: both entries are invalidated (no output, no shift). The 01 is dropped. Go to CODE.
  - CODE, vid_in_en: the byte is the code value. It is not inserted into the delay line.
    - Next cycle: start_code=byte, start_code_valid=1, unit_bytes=counter (including any byte emitted in the same cycle).
    - Counter is cleared to 0. Go to SCAN.
  - The code byte is never considered part of a following prefix, so a picture start code (00 00 01 00) followed by 00 01 is not a start code.
- Leading zeros beyond two (stuffing, e.g. 00 00 00 01) are not removed: the extra 00 leaves as data.
- Counter increments on every data_out_en and saturates at all-ones.
- flush: drain_cnt is set to 2.
  - Each shift decrements drain_cnt.
  - Input arriving during the drain is shifted in normally and still decrements drain_cnt.
  - flush while drain_cnt>0 reloads 2.
  - flush in CODE state returns to SCAN with no start_code_valid; the partial code is lost.
- Simultaneous flush and vid_in_en: the byte is accepted first, then drain_cnt=2 from the next cycle.
- busy = s0.valid or s1.valid.
- Outputs are registered; the strobes are high exactly one cycle.

Decomposition:
- Shared package (stream_pkg): BYTE_W=8, START_PREFIX values (8'h00, 8'h01), and codes PICTURE_SC=8'h00, SEQ_HDR_SC=8'hB3, SEQ_END_SC=8'hB7, SLICE_MIN=8'h01, SLICE_MAX=8'hAF.
- One natural sub-module: sc_delay_line (2-entry shift register with per-entry valid, kill and bubble insert). FSM and counter stay in the top.

Test Plan:
- Stream 00 00 01 B3 12 34 then flush:
  - start_code_valid once with start_code=B3, unit_bytes=0.
  - Data 12, 34 appear only after flush; no 00/01 bytes on data_out.
- Stream AA BB 00 00 01 00 CC then flush:
  - data AA, BB, then code 00 with unit_bytes=2, then data CC.
  - Total data_out_en count is 3.
- Stream 00 00 01 00 00 01 B5 (picture code then overlapping 00 01):
  - single code 00.
  - Data bytes 00, 01, B5 emitted after flush; no second code.
- Stream 00 00 00 01 B8:
  - data 00 (stuffing) emitted, then code B8 with unit_bytes=1.
- Back-to-back vid_in_en every cycle for 1000 random bytes containing no 00 00 01:
  - output equals input delayed, no drops, no start codes.
- rst asserted mid-stream after 00 00:
  - all outputs 0 immediately and busy=0.
  - After release, stream 01 B3 yields no start code; both bytes pass as data after flush.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared byte-stream constants for the video ES path: start-code prefix bytes,
// well-known MPEG code values and the scanner FSM state type.
package stream_pkg;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SC_PFX_ZERO = 8'h00;
  localparam logic [BYTE_W-1:0] SC_PFX_ONE  = 8'h01;

  localparam logic [BYTE_W-1:0] PICTURE_SC = 8'h00;
  localparam logic [BYTE_W-1:0] SEQ_HDR_SC = 8'hB3;
  localparam logic [BYTE_W-1:0] SEQ_END_SC = 8'hB7;
  localparam logic [BYTE_W-1:0] SLICE_MIN  = 8'h01;
  localparam logic [BYTE_W-1:0] SLICE_MAX  = 8'hAF;

  typedef enum logic {ST_SCAN, ST_CODE} sc_state_t;
endpackage

// File: rtl/sc_delay_line.sv
// Two-entry byte shift register with per-entry valid. Kill empties both
// entries and takes priority over a shift; a shift may insert a bubble.
module sc_delay_line
  import stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_shift,
  input  logic              i_kill,
  input  logic              i_ins_v,
  input  logic [BYTE_W-1:0] i_ins_d,
  output logic [BYTE_W-1:0] o_s0,
  output logic              o_s0_v,
  output logic [BYTE_W-1:0] o_s1,
  output logic              o_s1_v
);
  logic [BYTE_W-1:0] r_s0, r_s1;
  logic              r_s0_v, r_s1_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0   <= '0;
      r_s1   <= '0;
      r_s0_v <= 1'b0;
      r_s1_v <= 1'b0;
    end else if (i_kill) begin
      r_s0_v <= 1'b0;
      r_s1_v <= 1'b0;
    end else if (i_shift) begin
      r_s1   <= r_s0;
      r_s1_v <= r_s0_v;
      r_s0   <= i_ins_d;
      r_s0_v <= i_ins_v;
    end
  end

  assign o_s0   = r_s0;
  assign o_s0_v = r_s0_v;
  assign o_s1   = r_s1;
  assign o_s1_v = r_s1_v;
endmodule

// File: rtl/start_code_scanner.sv
// Strips MPEG start codes (00 00 01 xx) from the video ES byte stream, passing
// payload through a 2-entry delay line and reporting each code on a side channel.
module start_code_scanner
  import stream_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] vid_in,
  input  logic              vid_in_en,
  input  logic              flush,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_out_en,
  output logic [BYTE_W-1:0] start_code,
  output logic              start_code_valid,
  output logic [CNT_W-1:0]  unit_bytes,
  output logic              busy
);
  sc_state_t         r_state, w_state_nxt;
  logic [1:0]        r_drain;
  logic [CNT_W-1:0]  r_cnt, w_cnt_inc;
  logic [BYTE_W-1:0] w_s0, w_s1;
  logic              w_s0_v, w_s1_v;
  logic              w_in_scan, w_prefix, w_shift, w_code_take, w_emit;

  sc_delay_line u_dly (
    .clk     (clk),
    .rst_n   (rst),
    .i_shift (w_shift),
    .i_kill  (w_prefix),
    .i_ins_v (w_in_scan),
    .i_ins_d (vid_in),
    .o_s0    (w_s0),
    .o_s0_v  (w_s0_v),
    .o_s1    (w_s1),
    .o_s1_v  (w_s1_v)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_SCAN;
    else      r_state <= w_state_nxt;
  end

  // The 01 completing a prefix kills the two buffered zeros instead of shifting.
  always_comb begin
    w_state_nxt = r_state;
    w_in_scan   = vid_in_en && (r_state == ST_SCAN);
    w_prefix    = w_in_scan && (vid_in == SC_PFX_ONE) && w_s0_v && w_s1_v &&
                  (w_s0 == SC_PFX_ZERO) && (w_s1 == SC_PFX_ZERO);
    w_code_take = vid_in_en && (r_state == ST_CODE);
    w_shift     = (w_in_scan && !w_prefix) || (r_drain != 2'd0);
    case (r_state)
      ST_SCAN: if (w_prefix) w_state_nxt = ST_CODE;
      ST_CODE: if (vid_in_en || flush) w_state_nxt = ST_SCAN;
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  assign w_emit    = w_shift && w_s1_v;
  assign w_cnt_inc = (w_emit && (r_cnt != '1)) ? r_cnt + CNT_W'(1) : r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out         <= '0;
      data_out_en      <= 1'b0;
      start_code       <= '0;
      start_code_valid <= 1'b0;
      unit_bytes       <= '0;
      r_cnt            <= '0;
      r_drain          <= 2'd0;
    end else begin
      data_out_en      <= w_emit;
      start_code_valid <= w_code_take;
      if (w_emit) data_out <= w_s1;
      // A byte leaving in the same cycle as the code belongs to the closing unit.
      if (w_code_take) begin
        start_code <= vid_in;
        unit_bytes <= w_cnt_inc;
        r_cnt      <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
      if (flush)                          r_drain <= 2'd2;
      else if (w_shift && r_drain != 2'd0) r_drain <= r_drain - 2'd1;
    end
  end

  assign busy = w_s0_v || w_s1_v;
endmodule

// File: tb/tb_start_code_scanner.sv
// Directed bench for start_code_scanner: collects data/code events at negedge
// and compares them against hand-computed expected sequences.
module tb_start_code_scanner;
  typedef logic [7:0] bq_t[$];

  logic        clk, rst, vid_in_en, flush;
  logic [7:0]  vid_in;
  logic [7:0]  data_out, start_code;
  logic        data_out_en, start_code_valid, busy;
  logic [15:0] unit_bytes;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  dq[$];
  logic [7:0]  cq[$];
  logic [15:0] uq[$];
  int          pq[$];

  start_code_scanner #(.CNT_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .vid_in           (vid_in),
    .vid_in_en        (vid_in_en),
    .flush            (flush),
    .data_out         (data_out),
    .data_out_en      (data_out_en),
    .start_code       (start_code),
    .start_code_valid (start_code_valid),
    .unit_bytes       (unit_bytes),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (data_out_en) dq.push_back(data_out);
      if (start_code_valid) begin
        cq.push_back(start_code);
        uq.push_back(unit_bytes);
        pq.push_back(dq.size());
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic clr_q();
    dq.delete(); cq.delete(); uq.delete(); pq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; vid_in_en = 1'b0; flush = 1'b0; vid_in = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    clr_q();
  endtask

  task automatic send(input logic [7:0] b);
    vid_in = b; vid_in_en = 1'b1;
    @(posedge clk); #1;
    vid_in_en = 1'b0;
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_data(input string tag, input bq_t exp);
    chk({tag, "_ndata"}, 32'(dq.size()), 32'(exp.size()));
    foreach (exp[i])
      if (i < dq.size()) chk($sformatf("%s_d%0d", tag, i), 32'(dq[i]), 32'(exp[i]));
  endtask

  task automatic chk_out_zero(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'h0);
    chk({tag, "_data_en"},  32'(data_out_en), 32'h0);
    chk({tag, "_sc"},       32'(start_code), 32'h0);
    chk({tag, "_sc_v"},     32'(start_code_valid), 32'h0);
    chk({tag, "_ub"},       32'(unit_bytes), 32'h0);
    chk({tag, "_busy"},     32'(busy), 32'h0);
  endtask

  initial begin
    bq_t in_q;
    logic [7:0] b, p0, p1;
    int mism;

    rst = 1'b0; vid_in_en = 1'b0; flush = 1'b0; vid_in = 8'h00;
    #12;
    chk_out_zero("rst0");
    rst = 1'b1;
    @(posedge clk); #1;
    clr_q();

    // sequence header code, payload held until flush
    send_seq('{8'h00, 8'h00, 8'h01, 8'hB3, 8'h12, 8'h34});
    @(posedge clk); #1;
    chk("t1_preflush_n", 32'(dq.size()), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    do_flush();
    chk("t1_ncode", 32'(cq.size()), 32'd1);
    if (cq.size() > 0) begin
      chk("t1_code", 32'(cq[0]), 32'hB3);
      chk("t1_ub", 32'(uq[0]), 32'd0);
    end
    chk_data("t1", '{8'h12, 8'h34});
    chk("t1_busy_end", 32'(busy), 32'd0);

    // picture code between payload bytes
    do_reset();
    send_seq('{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h01, 8'h00, 8'hCC});
    do_flush();
    chk("t2_ncode", 32'(cq.size()), 32'd1);
    if (cq.size() > 0) begin
      chk("t2_code", 32'(cq[0]), 32'h00);
      chk("t2_ub", 32'(uq[0]), 32'd2);
      chk("t2_pos", 32'(pq[0]), 32'd2);
    end
    chk_data("t2", '{8'hAA, 8'hBB, 8'hCC});

    // code byte must not seed a following prefix
    do_reset();
    send_seq('{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'hB5});
    do_flush();
    chk("t3_ncode", 32'(cq.size()), 32'd1);
    if (cq.size() > 0) chk("t3_code", 32'(cq[0]), 32'h00);
    chk_data("t3", '{8'h00, 8'h01, 8'hB5});

    // stuffing zero leaves as data
    do_reset();
    send_seq('{8'h00, 8'h00, 8'h00, 8'h01, 8'hB8});
    do_flush();
    chk("t4_ncode", 32'(cq.size()), 32'd1);
    if (cq.size() > 0) begin
      chk("t4_code", 32'(cq[0]), 32'hB8);
      chk("t4_ub", 32'(uq[0]), 32'd1);
    end
    chk_data("t4", '{8'h00});

    // back-to-back random bytes free of 00 00 01
    do_reset();
    in_q.delete();
    p0 = 8'hFF; p1 = 8'hFF;
    for (int i = 0; i < 1000; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) b = 8'h00;
      if (p1 == 8'h00 && p0 == 8'h00 && b == 8'h01) b = 8'h02;
      p1 = p0; p0 = b;
      in_q.push_back(b);
    end
    send_seq(in_q);
    do_flush();
    chk("t5_ncode", 32'(cq.size()), 32'd0);
    chk("t5_ndata", 32'(dq.size()), 32'd1000);
    mism = 0;
    for (int i = 0; i < 1000; i++)
      if (i >= dq.size() || dq[i] !== in_q[i]) mism++;
    chk("t5_mism", 32'(mism), 32'd0);

    // async reset in the middle of a prefix
    do_reset();
    send_seq('{8'hAA, 8'h00, 8'h00});
    chk("t6_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_out_zero("t6_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    clr_q();
    send_seq('{8'h01, 8'hB3});
    do_flush();
    chk("t6_ncode", 32'(cq.size()), 32'd0);
    chk_data("t6", '{8'h01, 8'hB3});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
